// File: rtl/hpdcache_mem_read_remap_arbiter.sv
// N-port round-robin read arbiter with dynamic memory-TID remapping.
// Requester IDs are stored per allocated TID and restored on every response beat.
module hpdcache_mem_read_remap_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned IN_ID_W  = 4,
  parameter int unsigned OUT_ID_W = 4,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N-1:0]          req_valid_i,
  output logic [N-1:0]          req_ready_o,
  input  logic [N*ADDR_W-1:0]   req_addr_i,
  input  logic [N*LEN_W-1:0]    req_len_i,
  input  logic [N*3-1:0]        req_size_i,
  input  logic [N*IN_ID_W-1:0]  req_id_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_W-1:0]     mem_req_addr_o,
  output logic [LEN_W-1:0]      mem_req_len_o,
  output logic [2:0]            mem_req_size_o,
  output logic [OUT_ID_W-1:0]   mem_req_id_o,
  input  logic                  mem_resp_valid_i,
  output logic                  mem_resp_ready_o,
  input  logic [OUT_ID_W-1:0]   mem_resp_id_i,
  input  logic [DATA_W-1:0]     mem_resp_data_i,
  input  logic [1:0]            mem_resp_error_i,
  input  logic                  mem_resp_last_i,
  output logic [N-1:0]          resp_valid_o,
  input  logic [N-1:0]          resp_ready_i,
  output logic [DATA_W-1:0]     resp_data_o,
  output logic [1:0]            resp_error_o,
  output logic [IN_ID_W-1:0]    resp_id_o,
  output logic                  resp_last_o,
  output logic                  busy_o,
  output logic                  unexp_resp_o
);

  localparam int unsigned NE = 1 << OUT_ID_W;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  typedef logic [PW-1:0]       port_t;
  typedef logic [OUT_ID_W-1:0] tid_t;
  typedef logic [CW-1:0]       cnt_t;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_e;

  logic [NE-1:0]      tblValid_q, tblValid_d;
  port_t              tblPort_q [NE];
  logic [IN_ID_W-1:0] tblId_q [NE];
  cnt_t               cnt_q [N];
  cnt_t               cnt_d [N];
  port_t              rrPtr_q, rrPtr_d;
  lock_e              lockState_q, lockState_d;
  port_t              lockPort_q, lockPort_d;
  tid_t               lockTid_q, lockTid_d;
  logic               unexp_q, unexp_d;

  logic               anyFree;
  tid_t               freeTid;
  logic [N-1:0]       eligible;
  port_t              rrPick;
  logic               rrFound;
  port_t              grantPort;
  tid_t               grantTid;
  logic               memReqValid;
  logic               reqHs;
  logic [IN_ID_W-1:0] grantOrigId;
  logic               entryValid;
  port_t              entryPort;
  logic               respHs;
  logic               freeEn;

  always_comb begin
    anyFree = ~(&tblValid_q);
    freeTid = '0;
    for (int k = NE - 1; k >= 0; k--) begin
      if (!tblValid_q[k]) freeTid = tid_t'(k);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < cnt_t'(MAX_OUT)) && anyFree;
    end
  end

  // Round-robin search starting at the pointer, wrapping modulo N.
  always_comb begin
    int    j;
    port_t jp;
    rrPick  = '0;
    rrFound = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(rrPtr_q) + k;
      if (j >= int'(N)) j = j - int'(N);
      jp = port_t'(j);
      if (!rrFound && eligible[jp]) begin
        rrFound = 1'b1;
        rrPick  = jp;
      end
    end
  end

  always_comb begin
    if (lockState_q == LOCK_HELD) begin
      grantPort   = lockPort_q;
      grantTid    = lockTid_q;
      memReqValid = rst_ni;
    end else begin
      grantPort   = rrPick;
      grantTid    = freeTid;
      memReqValid = rst_ni & rrFound;
    end
  end

  assign reqHs = memReqValid & mem_req_ready_i;

  always_comb begin
    mem_req_addr_o = '0;
    mem_req_len_o  = '0;
    mem_req_size_o = '0;
    grantOrigId    = '0;
    for (int i = 0; i < N; i++) begin
      if (port_t'(i) == grantPort) begin
        mem_req_addr_o = req_addr_i[i*ADDR_W +: ADDR_W];
        mem_req_len_o  = req_len_i[i*LEN_W +: LEN_W];
        mem_req_size_o = req_size_i[i*3 +: 3];
        grantOrigId    = req_id_i[i*IN_ID_W +: IN_ID_W];
      end
    end
  end

  assign mem_req_valid_o = memReqValid;
  assign mem_req_id_o    = grantTid;

  always_comb begin
    req_ready_o = '0;
    if (reqHs) req_ready_o[grantPort] = 1'b1;
  end

  // A stalled offer is frozen so the downstream sees stable fields and TID.
  always_comb begin
    lockState_d = lockState_q;
    lockPort_d  = lockPort_q;
    lockTid_d   = lockTid_q;
    case (lockState_q)
      LOCK_IDLE: begin
        if (memReqValid && !mem_req_ready_i) begin
          lockState_d = LOCK_HELD;
          lockPort_d  = grantPort;
          lockTid_d   = grantTid;
        end
      end
      LOCK_HELD: begin
        if (mem_req_ready_i) lockState_d = LOCK_IDLE;
      end
      default: lockState_d = LOCK_IDLE;
    endcase
  end

  assign entryValid = tblValid_q[mem_resp_id_i];
  assign entryPort  = tblPort_q[mem_resp_id_i];

  // Beats for unowned TIDs are swallowed so the downstream never deadlocks.
  always_comb begin
    resp_valid_o     = '0;
    mem_resp_ready_o = 1'b1;
    if (entryValid) begin
      resp_valid_o[entryPort] = mem_resp_valid_i;
      mem_resp_ready_o        = resp_ready_i[entryPort];
    end
  end

  assign resp_id_o    = tblId_q[mem_resp_id_i];
  assign resp_data_o  = mem_resp_data_i;
  assign resp_error_o = mem_resp_error_i;
  assign resp_last_o  = mem_resp_last_i;

  assign respHs = mem_resp_valid_i & mem_resp_ready_o;
  assign freeEn = respHs & entryValid & mem_resp_last_i;

  always_comb begin
    tblValid_d = tblValid_q;
    if (reqHs)  tblValid_d[grantTid]      = 1'b1;
    if (freeEn) tblValid_d[mem_resp_id_i] = 1'b0;
  end

  always_comb begin
    logic inc;
    logic dec;
    for (int i = 0; i < N; i++) begin
      inc      = reqHs && (grantPort == port_t'(i));
      dec      = freeEn && (entryPort == port_t'(i));
      cnt_d[i] = cnt_q[i] + cnt_t'(inc) - cnt_t'(dec);
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (reqHs) rrPtr_d = (grantPort == port_t'(N - 1)) ? '0 : grantPort + port_t'(1);
  end

  assign unexp_d = unexp_q | (mem_resp_valid_i & ~entryValid);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tblValid_q  <= '0;
      rrPtr_q     <= '0;
      lockState_q <= LOCK_IDLE;
      lockPort_q  <= '0;
      lockTid_q   <= '0;
      unexp_q     <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      tblValid_q  <= tblValid_d;
      rrPtr_q     <= rrPtr_d;
      lockState_q <= lockState_d;
      lockPort_q  <= lockPort_d;
      lockTid_q   <= lockTid_d;
      unexp_q     <= unexp_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reqHs) begin
      tblPort_q[grantTid] <= grantPort;
      tblId_q[grantTid]   <= grantOrigId;
    end
  end

  assign busy_o       = |tblValid_q;
  assign unexp_resp_o = unexp_q;

endmodule

// File: tb/tb_hpdcache_mem_read_remap_arbiter.sv
// Bench for the remap arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level table/counter model.
module tb_hpdcache_mem_read_remap_arbiter;

  localparam int N        = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 8;
  localparam int IN_ID_W  = 4;
  localparam int OUT_ID_W = 3;
  localparam int MAX_OUT  = 2;
  localparam int NE       = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]          reqValid;
  logic [ADDR_W-1:0]     reqAddr [N];
  logic [LEN_W-1:0]      reqLen [N];
  logic [2:0]            reqSize [N];
  logic [IN_ID_W-1:0]    reqId [N];
  logic [N*ADDR_W-1:0]   reqAddrFlat;
  logic [N*LEN_W-1:0]    reqLenFlat;
  logic [N*3-1:0]        reqSizeFlat;
  logic [N*IN_ID_W-1:0]  reqIdFlat;
  logic                  memReqReady;
  logic                  memRespValid;
  logic [OUT_ID_W-1:0]   memRespId;
  logic [DATA_W-1:0]     memRespData;
  logic [1:0]            memRespError;
  logic                  memRespLast;
  logic [N-1:0]          respReady;

  logic [N-1:0]          reqReadyO;
  logic                  memReqValidO;
  logic [ADDR_W-1:0]     memReqAddrO;
  logic [LEN_W-1:0]      memReqLenO;
  logic [2:0]            memReqSizeO;
  logic [OUT_ID_W-1:0]   memReqIdO;
  logic                  memRespReadyO;
  logic [N-1:0]          respValidO;
  logic [DATA_W-1:0]     respDataO;
  logic [1:0]            respErrorO;
  logic [IN_ID_W-1:0]    respIdO;
  logic                  respLastO;
  logic                  busyO;
  logic                  unexpO;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      reqAddrFlat[i*ADDR_W +: ADDR_W]   = reqAddr[i];
      reqLenFlat[i*LEN_W +: LEN_W]      = reqLen[i];
      reqSizeFlat[i*3 +: 3]             = reqSize[i];
      reqIdFlat[i*IN_ID_W +: IN_ID_W]   = reqId[i];
    end
  end

  hpdcache_mem_read_remap_arbiter #(
    .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(reqValid), .req_ready_o(reqReadyO),
    .req_addr_i(reqAddrFlat), .req_len_i(reqLenFlat),
    .req_size_i(reqSizeFlat), .req_id_i(reqIdFlat),
    .mem_req_valid_o(memReqValidO), .mem_req_ready_i(memReqReady),
    .mem_req_addr_o(memReqAddrO), .mem_req_len_o(memReqLenO),
    .mem_req_size_o(memReqSizeO), .mem_req_id_o(memReqIdO),
    .mem_resp_valid_i(memRespValid), .mem_resp_ready_o(memRespReadyO),
    .mem_resp_id_i(memRespId), .mem_resp_data_i(memRespData),
    .mem_resp_error_i(memRespError), .mem_resp_last_i(memRespLast),
    .resp_valid_o(respValidO), .resp_ready_i(respReady),
    .resp_data_o(respDataO), .resp_error_o(respErrorO),
    .resp_id_o(respIdO), .resp_last_o(respLastO),
    .busy_o(busyO), .unexp_resp_o(unexpO)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ownership table, per-port counts, RR pointer, held offer.
  logic               mValid [NE];
  int                 mPort [NE];
  logic [IN_ID_W-1:0] mId [NE];
  int                 mCnt [N];
  int                 mRr;
  logic               mLocked;
  int                 mLockPort;
  int                 mLockTid;
  logic               mUnexp;
  logic               inReset = 1'b0;

  logic               eValid;
  int                 ePort;
  int                 eTid;
  logic [N-1:0]       eReqReady;
  logic [N-1:0]       eRespValid;
  logic               eMemRespReady;
  logic               eEntryValid;
  int                 eEntryPort;

  typedef struct { int tid; int beats; } burst_t;
  burst_t memQ [$];
  int     curIdx = 0;
  logic   stray = 1'b0;
  logic   respHold = 1'b0;
  logic   randomMode = 1'b0;
  logic [N-1:0] lastAccept = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NE; k++) begin
      mValid[k] = 1'b0;
      mPort[k]  = 0;
      mId[k]    = '0;
    end
    for (int p = 0; p < N; p++) mCnt[p] = 0;
    mRr = 0;
    mLocked = 1'b0;
    mLockPort = 0;
    mLockTid = 0;
    mUnexp = 1'b0;
  endtask

  task automatic modelPredict();
    int p;
    eTid = -1;
    for (int k = NE - 1; k >= 0; k--) if (!mValid[k]) eTid = k;
    eValid = 1'b0;
    ePort = 0;
    if (mLocked) begin
      eValid = 1'b1;
      ePort  = mLockPort;
      eTid   = mLockTid;
    end else begin
      for (int k = 0; k < N; k++) begin
        p = (mRr + k) % N;
        if (!eValid && reqValid[p] && mCnt[p] < MAX_OUT && eTid >= 0) begin
          eValid = 1'b1;
          ePort  = p;
        end
      end
    end
    if (inReset) eValid = 1'b0;
    eReqReady = '0;
    if (eValid && memReqReady) eReqReady[ePort] = 1'b1;
    eEntryValid = mValid[memRespId];
    eEntryPort  = mPort[memRespId];
    eRespValid  = '0;
    if (memRespValid && eEntryValid) eRespValid[eEntryPort] = 1'b1;
    eMemRespReady = eEntryValid ? respReady[eEntryPort] : 1'b1;
  endtask

  task automatic modelCheck();
    logic anyValid;
    anyValid = 1'b0;
    for (int k = 0; k < NE; k++) anyValid |= mValid[k];
    checkOutput("mem_req_valid", memReqValidO, eValid);
    checkOutput("req_ready", reqReadyO, eReqReady);
    if (eValid) begin
      checkOutput("mem_req_id", memReqIdO, eTid);
      checkOutput("mem_req_addr", memReqAddrO, reqAddr[ePort]);
      checkOutput("mem_req_len", memReqLenO, reqLen[ePort]);
      checkOutput("mem_req_size", memReqSizeO, reqSize[ePort]);
    end
    checkOutput("resp_valid", respValidO, eRespValid);
    checkOutput("mem_resp_ready", memRespReadyO, eMemRespReady);
    if (eRespValid != '0) begin
      checkOutput("resp_id", respIdO, mId[memRespId]);
      checkOutput("resp_data", respDataO, memRespData);
      checkOutput("resp_last", respLastO, memRespLast);
      checkOutput("resp_error", respErrorO, memRespError);
    end
    checkOutput("busy", busyO, anyValid);
    checkOutput("unexp", unexpO, mUnexp);
  endtask

  task automatic modelUpdate();
    burst_t b;
    if (eValid) begin
      if (memReqReady) begin
        mValid[eTid] = 1'b1;
        mPort[eTid]  = ePort;
        mId[eTid]    = reqId[ePort];
        mCnt[ePort]++;
        mRr = (ePort + 1) % N;
        mLocked = 1'b0;
        if (randomMode) begin
          b.tid = eTid;
          b.beats = int'(reqLen[ePort]) + 1;
          memQ.push_back(b);
        end
      end else begin
        mLocked = 1'b1;
        mLockPort = ePort;
        mLockTid = eTid;
      end
    end
    if (memRespValid) begin
      if (eEntryValid) begin
        if (respReady[eEntryPort] && memRespLast) begin
          mValid[memRespId] = 1'b0;
          mCnt[eEntryPort]--;
        end
      end else begin
        mUnexp = 1'b1;
      end
      if (randomMode && eMemRespReady && !stray) begin
        memQ[curIdx].beats--;
        if (memQ[curIdx].beats == 0) memQ.delete(curIdx);
      end
    end
    respHold = memRespValid && !eMemRespReady;
    lastAccept = eReqReady;
  endtask

  task automatic settleCheck();
    #1;
    modelPredict();
    modelCheck();
  endtask

  task automatic advance();
    @(posedge clk);
    if (!inReset) modelUpdate();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    reqValid = '0;
    for (int p = 0; p < N; p++) begin
      reqAddr[p] = '0;
      reqLen[p]  = '0;
      reqSize[p] = '0;
      reqId[p]   = '0;
    end
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    memRespId    = '0;
    memRespData  = '0;
    memRespError = '0;
    memRespLast  = 1'b0;
    respReady    = '0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    inReset = 1'b1;
    settleCheck();
    advance();
    rst_n = 1'b1;
    inReset = 1'b0;
    respHold = 1'b0;
    lastAccept = '0;
    stray = 1'b0;
  endtask

  function automatic logic tidInQueue(input int t);
    foreach (memQ[i]) if (memQ[i].tid == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic applyStimulus();
    int r;
    int t;
    for (int p = 0; p < N; p++) begin
      if (!(reqValid[p] && !lastAccept[p])) begin
        if ($urandom_range(0, 99) < 50) begin
          reqValid[p] = 1'b1;
          reqAddr[p]  = $urandom;
          reqLen[p]   = LEN_W'($urandom_range(0, 3));
          reqSize[p]  = 3'($urandom_range(0, 7));
          reqId[p]    = IN_ID_W'($urandom_range(0, 15));
        end else begin
          reqValid[p] = 1'b0;
        end
      end
      respReady[p] = ($urandom_range(0, 99) < 80);
    end
    memReqReady = ($urandom_range(0, 99) < 70);
    if (!respHold) begin
      memRespValid = 1'b0;
      memRespLast  = 1'b0;
      stray = 1'b0;
      r = $urandom_range(0, 99);
      if (memQ.size() > 0 && r < 60) begin
        curIdx = $urandom_range(0, memQ.size() - 1);
        memRespValid = 1'b1;
        memRespId    = OUT_ID_W'(memQ[curIdx].tid);
        memRespLast  = (memQ[curIdx].beats == 1);
      end else if (r >= 95) begin
        t = $urandom_range(0, NE - 1);
        if (!mValid[t] && !tidInQueue(t)) begin
          stray = 1'b1;
          memRespValid = 1'b1;
          memRespId    = OUT_ID_W'(t);
          memRespLast  = 1'($urandom_range(0, 1));
        end
      end
      memRespData  = $urandom;
      memRespError = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    clearInputs();
    modelReset();
    @(negedge clk);
    resetDut();
    checkOutput("rst_req_valid", memReqValidO, 0);
    checkOutput("rst_busy", busyO, 0);

    // Single request from port 2 and its one-beat response.
    reqValid = 4'b0100;
    reqAddr[2] = 32'h8000_0040;
    reqId[2] = 4'd5;
    reqLen[2] = 8'd0;
    reqSize[2] = 3'd3;
    memReqReady = 1'b1;
    respReady = 4'hF;
    settleCheck();
    checkOutput("t1_tid", memReqIdO, 0);
    checkOutput("t1_ready", reqReadyO, 4'b0100);
    advance();
    reqValid = '0;
    memRespValid = 1'b1;
    memRespId = 3'd0;
    memRespLast = 1'b1;
    memRespData = 32'hCAFE_0001;
    settleCheck();
    checkOutput("t1_resp_valid", respValidO, 4'b0100);
    checkOutput("t1_resp_id", respIdO, 5);
    checkOutput("t1_busy_before", busyO, 1);
    advance();
    memRespValid = 1'b0;
    settleCheck();
    checkOutput("t1_busy_after", busyO, 0);
    advance();

    // Fairness and table-full, then reuse of a freed TID.
    resetDut();
    reqValid = 4'hF;
    for (int p = 0; p < N; p++) begin
      reqAddr[p] = 32'h1000 * (p + 1);
      reqId[p] = IN_ID_W'(p + 8);
    end
    memReqReady = 1'b1;
    respReady = 4'hF;
    for (int c = 0; c < 8; c++) begin
      settleCheck();
      checkOutput("t2_grant", reqReadyO, 4'b0001 << (c % 4));
      checkOutput("t2_tid", memReqIdO, c);
      advance();
      reqAddr[c % 4] = reqAddr[c % 4] + 32'h40;
    end
    settleCheck();
    checkOutput("t2_full_valid", memReqValidO, 0);
    advance();
    memRespValid = 1'b1;
    memRespId = 3'd2;
    memRespLast = 1'b1;
    settleCheck();
    checkOutput("t2_free_route", respValidO, 4'b0100);
    advance();
    memRespValid = 1'b0;
    settleCheck();
    checkOutput("t2_reuse_tid", memReqIdO, 2);
    checkOutput("t2_reuse_port", reqReadyO, 4'b0100);
    advance();

    // Backpressure lock: port 1 stays granted while port 0 arrives.
    resetDut();
    reqValid = 4'b0010;
    reqAddr[1] = 32'h1111_0000;
    reqAddr[0] = 32'h0000_AAAA;
    respReady = 4'hF;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) reqValid = 4'b0011;
      settleCheck();
      checkOutput("t3_lock_addr", memReqAddrO, 32'h1111_0000);
      checkOutput("t3_lock_tid", memReqIdO, 0);
      advance();
    end
    memReqReady = 1'b1;
    settleCheck();
    checkOutput("t3_first", reqReadyO, 4'b0010);
    advance();
    reqValid = 4'b0001;
    settleCheck();
    checkOutput("t3_second", reqReadyO, 4'b0001);
    checkOutput("t3_second_tid", memReqIdO, 1);
    advance();

    // Per-port outstanding limit on port 3.
    resetDut();
    reqValid = 4'b1000;
    memReqReady = 1'b1;
    respReady = 4'hF;
    for (int c = 0; c < 2; c++) begin
      settleCheck();
      checkOutput("t4_accept", reqReadyO, 4'b1000);
      advance();
    end
    reqValid = 4'b1001;
    settleCheck();
    checkOutput("t4_other_port", reqReadyO, 4'b0001);
    advance();
    reqValid = 4'b1000;
    settleCheck();
    checkOutput("t4_blocked", reqReadyO, 4'b0000);
    advance();
    memRespValid = 1'b1;
    memRespId = 3'd0;
    memRespLast = 1'b1;
    settleCheck();
    checkOutput("t4_resp_route", respValidO, 4'b1000);
    checkOutput("t4_still_blocked", reqReadyO, 4'b0000);
    advance();
    memRespValid = 1'b0;
    settleCheck();
    checkOutput("t4_unblocked", reqReadyO, 4'b1000);
    checkOutput("t4_tid", memReqIdO, 0);
    advance();

    // Unexpected TID and interleaved bursts with port 1 stalled.
    resetDut();
    respReady = 4'hF;
    memRespValid = 1'b1;
    memRespId = 3'd7;
    settleCheck();
    checkOutput("t5_drop_ready", memRespReadyO, 1);
    checkOutput("t5_drop_valid", respValidO, 0);
    advance();
    memRespValid = 1'b0;
    settleCheck();
    checkOutput("t5_unexp", unexpO, 1);
    advance();
    reqValid = 4'b0011;
    reqLen[0] = 8'd3;
    reqLen[1] = 8'd3;
    reqId[0] = 4'hA;
    reqId[1] = 4'hB;
    memReqReady = 1'b1;
    settleCheck();
    checkOutput("t5_alloc0", reqReadyO, 4'b0001);
    advance();
    reqValid = 4'b0010;
    settleCheck();
    checkOutput("t5_alloc1", reqReadyO, 4'b0010);
    advance();
    reqValid = '0;
    respReady = 4'b0001;
    memRespValid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      memRespId = 3'd0;
      memRespLast = (b == 3);
      settleCheck();
      checkOutput("t5_tid0_route", respValidO, 4'b0001);
      checkOutput("t5_tid0_ready", memRespReadyO, 1);
      checkOutput("t5_tid0_id", respIdO, 4'hA);
      advance();
      memRespId = 3'd1;
      memRespLast = 1'b0;
      settleCheck();
      checkOutput("t5_tid1_route", respValidO, 4'b0010);
      checkOutput("t5_tid1_stall", memRespReadyO, 0);
      advance();
    end
    respReady = 4'hF;
    for (int b = 0; b < 4; b++) begin
      memRespId = 3'd1;
      memRespLast = (b == 3);
      settleCheck();
      checkOutput("t5_tid1_drain", memRespReadyO, 1);
      checkOutput("t5_tid1_id", respIdO, 4'hB);
      advance();
    end
    memRespValid = 1'b0;
    settleCheck();
    checkOutput("t5_idle", busyO, 0);
    checkOutput("t5_sticky", unexpO, 1);
    advance();

    // Randomized traffic with a mid-run reset; stale bursts keep flowing after it.
    resetDut();
    memQ.delete();
    randomMode = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) resetDut();
      applyStimulus();
      settleCheck();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hpdcache_mem_read_remap_arbiter.md
Name: hpdcache_mem_read_remap_arbiter

Overview:
- Generalised N-requester read arbiter and response router for the HPDcache memory read path. Sits between N cache read interfaces (I$ miss, I$ uncached, D$ miss, D$ uncached, and further ports) and one hpdcache_mem_to_axi_read adapter.
- Replaces static per-port ID routing with dynamic transaction-ID remapping. Each requester keeps its own ID space. The block allocates a free memory TID per request, tracks ownership in a table, and restores the original ID on the response.
- Adds a per-port outstanding-request limit and round-robin fairness.

Parameters:
- N, 4, number of requester ports (2..8)
- ADDR_W, 64, request address width
- DATA_W, 128, response data width
- LEN_W, 8, burst length field width (beats minus 1)
- IN_ID_W, 4, requester-side ID width
- OUT_ID_W, 4, memory-side TID width; the table has 2**OUT_ID_W entries
- MAX_OUT, 4, maximum outstanding requests per port (1..2**OUT_ID_W)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  N  per-port request valid
- req_ready_o  out  N  per-port request ready
- req_addr_i  in  N*ADDR_W  per-port address, port i at slice i
- req_len_i  in  N*LEN_W  per-port burst length
- req_size_i  in  N*3  per-port beat size
- req_id_i  in  N*IN_ID_W  per-port original ID
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream request ready
- mem_req_addr_o  out  ADDR_W  forwarded address
- mem_req_len_o  out  LEN_W  forwarded length
- mem_req_size_o  out  3  forwarded size
- mem_req_id_o  out  OUT_ID_W  allocated TID
- mem_resp_valid_i  in  1  downstream response valid
- mem_resp_ready_o  out  1  downstream response ready
- mem_resp_id_i  in  OUT_ID_W  response TID
- mem_resp_data_i  in  DATA_W  response data
- mem_resp_error_i  in  2  response error code
- mem_resp_last_i  in  1  last beat
- resp_valid_o  out  N  per-port response valid
- resp_ready_i  in  N  per-port response ready
- resp_data_o  out  DATA_W  response data, shared by all ports
- resp_error_o  out  2  response error, shared
- resp_id_o  out  IN_ID_W  restored original ID, shared
- resp_last_o  out  1  last beat, shared
- busy_o  out  1  at least one table entry valid
- unexp_resp_o  out  1  sticky flag: response arrived for an unallocated TID

Behaviour:
- Reset: all table entries invalid, per-port counters 0, RR pointer 0, grant unlocked, unexp_resp_o 0. Every valid/ready output is 0 during and immediately after reset, except mem_resp_ready_o, which follows the response rules below.
- Eligibility: port i is eligible when req_valid_i[i] is high, cnt[i] < MAX_OUT, and the table has at least one free entry.
- Arbitration is combinational round-robin over eligible ports, starting at the RR pointer. On a request handshake the pointer advances to granted+1 mod N.
- Grant lock: once mem_req_valid_o is high and mem_req_ready_i is low, the granted port and the allocated TID are registered and held until the handshake. Forwarded fields stay stable. Requesters must keep their valid and payload stable (AXI rules).
- mem_req_valid_o = at least one port eligible, or the grant is locked. mem_req_*_o mux the granted port. mem_req_id_o = lowest-index free entry, or the locked TID.
- req_ready_o[i] = grant[i] & mem_req_ready_i. Zero added latency: the request passes through combinationally in the cycle of acceptance.
- Request handshake: table[tid] <= {valid=1, port, orig_id}; cnt[port]++.
- Response routing: e = table[mem_resp_id_i].
  - Entry valid: resp_valid_o[e.port] = mem_resp_valid_i, all other bits 0; mem_resp_ready_o = resp_ready_i[e.port]; resp_id_o = e.orig_id; data, error and last pass through combinationally.
  - Handshake with last: clear the entry and decrement cnt[e.port].
  - Entry invalid: mem_resp_ready_o = 1 (the beat is dropped), resp_valid_o = 0, unexp_resp_o set. It clears only on reset.
- Simultaneous allocate and free in one cycle: both take effect. Allocation uses the pre-update free vector, so a freed entry is reusable from the next cycle. A counter on the same port sees both increment and decrement, net unchanged.
- Full table: no port is eligible and mem_req_valid_o = 0, unless a grant is locked.
- Per-port limit reached: only that port is blocked; other ports continue.
- Multi-beat responses may interleave across TIDs. Routing is evaluated per beat.
- A mid-operation reset discards all in-flight state. Responses arriving after reset set unexp_resp_o.

Test Plan:
- Single request: port 2 sends addr 0x8000_0040, id 5, len 0. Required: mem_req_id_o=0 in the same cycle. A response with TID 0 and last=1 gives resp_valid_o=4'b0100, resp_id_o=5, and busy_o drops the next cycle.
- Fairness: all 4 ports request continuously with mem_req_ready_i=1. Required grant order 0,1,2,3,0,1,2,3. TIDs 0..7 allocated in order.
- Backpressure lock: mem_req_ready_i=0 for 3 cycles while port 1 is granted and port 0 raises valid. Required: grant, addr and TID stable for all 3 cycles; port 1 is accepted first.
- Limits: MAX_OUT=2, port 3 issues 3 requests with no responses. Required: the third request is not accepted (req_ready_o[3]=0) while port 0 is still accepted. After one last-beat response to port 3, the third request is accepted.
- Table full: OUT_ID_W=2, 4 outstanding requests. Required: mem_req_valid_o=0. A response on TID 2 (last) is freed, and the next request gets TID 2 the following cycle.
- Unexpected and interleaved responses: a response on an unallocated TID 7 gives mem_resp_ready_o=1 and unexp_resp_o=1 sticky. Interleaved 4-beat responses on TIDs 0 and 1, owned by ports 0 and 1, route beat by beat. Required: resp_ready_i[1]=0 stalls only TID 1 beats, with mem_resp_ready_o=0 on those beats.
